// File: rtl/arith4_seq.sv
// Sequencer ahead of the 4-operation arithmetic core: latches one operand pair,
// sweeps the core select, captures each result, then streams results out.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start; core operands hold their last values
// RUN   | one select code per cycle, capturing i_core_y into slots
// OUT   | streaming slots over o_dout/o_dvalid/i_dready
module arith4_seq #(
  parameter int DW   = 8,
  parameter int NOPS = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_core_a,
  output logic [DW-1:0] o_core_b,
  output logic [1:0]    o_core_sel,
  input  logic [DW-1:0] i_core_y,
  output logic [DW-1:0] o_dout,
  output logic          o_dvalid,
  input  logic          i_dready,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [1:0] LAST = 2'(NOPS - 1);

  logic [1:0]    state;
  logic [1:0]    step;
  logic [1:0]    idx;
  logic [DW-1:0] slot [NOPS];

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      step       <= '0;
      idx        <= '0;
      o_core_a   <= '0;
      o_core_b   <= '0;
      o_core_sel <= '0;
      o_dout     <= '0;
      o_dvalid   <= 1'b0;
      o_done     <= 1'b0;
      for (int i = 0; i < NOPS; i++) slot[i] <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            o_core_a   <= i_a;
            o_core_b   <= i_b;
            o_core_sel <= '0;
            step       <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          slot[step] <= i_core_y;
          if (step == LAST) begin
            state    <= ST_OUT;
            idx      <= '0;
            o_dvalid <= 1'b1;
            // slot[0] may be written on this very edge when only one op is swept
            o_dout   <= (step == 2'd0) ? i_core_y : slot[0];
          end else begin
            step       <= step + 1'b1;
            o_core_sel <= o_core_sel + 1'b1;
          end
        end
        ST_OUT: begin
          if (o_dvalid && i_dready) begin
            if (idx == LAST) begin
              o_dvalid <= 1'b0;
              o_done   <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              idx    <= idx + 1'b1;
              o_dout <= slot[idx + 1'b1];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith4_seq.sv
// Directed bench for arith4_seq with a stub core y = a + b + sel (mod 256).
module tb_arith4_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] core_a, core_b, core_y, dout;
  logic [1:0] core_sel;
  logic       dvalid, busy, done;
  logic       dready = 1'b1;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;

  assign core_y = core_a + core_b + {6'b0, core_sel};

  arith4_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_core_a(core_a), .o_core_b(core_b), .o_core_sel(core_sel),
    .i_core_y(core_y), .o_dout(dout), .o_dvalid(dvalid), .i_dready(dready),
    .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_core_a"}, core_a, 0);
    chk({tag, "_core_b"}, core_b, 0);
    chk({tag, "_sel"}, core_sel, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dvalid"}, dvalid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Leaves the bench at the negedge just after the start edge.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // pat is the ready value applied on successive valid cycles, LSB first.
  task automatic do_stream(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input logic [6:0] pat, input bit poke, input string tag);
    logic [7:0] exp [4];
    logic [7:0] held;
    logic       held_v;
    int n, p, cyc;
    exp = '{e0, e1, e2, e3};
    n = 0; p = 0; cyc = 0; held_v = 1'b0; held = '0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (held_v) begin
        chk({tag, "_hold"}, {dvalid, dout}, {1'b1, held});
        held_v = 1'b0;
      end
      if (dvalid) begin
        dready = (p < 7) ? pat[p] : 1'b1;
        p++;
        if (poke && p == 2) begin
          start = 1'b1; a = 8'd15; b = 8'd15;
        end
        if (dready) begin
          chk({tag, "_dout"}, dout, exp[n]);
          n++;
        end else begin
          held = dout;
          held_v = 1'b1;
        end
      end
    end
    if (n != 4) chk({tag, "_timeout"}, n, 4);
    @(negedge clk);
    start = 1'b0;
    dready = 1'b1;
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_dvalid_off"}, dvalid, 0);
    chk({tag, "_busy_off"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    logic saw_done;
    int s, d1, d2, k;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // basic sweep and stream
    issue(8'd2, 8'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("t1_sel", core_sel, i);
      chk("t1_busy", busy, 1);
      chk("t1_novalid", dvalid, 0);
    end
    do_stream(8'd3, 8'd4, 8'd5, 8'd6, 7'h7F, 1'b0, "t1");
    chk("t1_sel_hold", core_sel, 3);

    // back-pressure
    issue(8'd100, 8'd97);
    do_stream(8'd197, 8'd198, 8'd199, 8'd200, 7'b1101001, 1'b0, "t2");

    // modulo wrap from the core
    issue(8'd255, 8'd255);
    do_stream(8'd254, 8'd255, 8'd0, 8'd1, 7'h7F, 1'b0, "t3");

    // start pulses during RUN and OUT are ignored
    issue(8'd2, 8'd1);
    @(negedge clk);
    start = 1'b1; a = 8'd15; b = 8'd15;
    @(negedge clk);
    start = 1'b0;
    chk("t4_run_a", core_a, 2);
    do_stream(8'd3, 8'd4, 8'd5, 8'd6, 7'h7F, 1'b1, "t4");
    chk("t4_out_a", core_a, 2);
    issue(8'd15, 8'd15);
    do_stream(8'd30, 8'd31, 8'd32, 8'd33, 7'h7F, 1'b0, "t4b");

    // reset in second RUN cycle
    issue(8'd2, 8'd1);
    @(negedge clk);
    chk("t5_sel1", core_sel, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("t5_run_rst");
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t5_no_done_run", saw_done, 0);

    // reset during OUT with idx=2
    issue(8'd2, 8'd1);
    repeat (4) @(negedge clk);
    chk("t5_out0", dout, 3);
    @(negedge clk);
    chk("t5_out1", dout, 4);
    @(negedge clk);
    chk("t5_out2", dout, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("t5_out_rst");
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t5_no_done_out", saw_done, 0);
    issue(8'd2, 8'd1);
    do_stream(8'd3, 8'd4, 8'd5, 8'd6, 7'h7F, 1'b0, "t5");

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 8'd2; b = 8'd1; dready = 1'b1;
    s = ecnt + 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 30);
    chk("t6_done1_seen", done, 1);
    d1 = ecnt;
    chk("t6_latency", d1 - s + 1, 9);
    @(negedge clk);
    chk("t6_rerun_busy", busy, 1);
    chk("t6_rerun_sel", core_sel, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 30);
    chk("t6_done2_seen", done, 1);
    d2 = ecnt;
    chk("t6_period", d2 - d1, 9);
    start = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 30);
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
